// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum output is enabled with the IMEM_CHECKSUM_EN macro.
package imem_pkg;

    localparam int          IMEM_DEPTH = 64;
    localparam int          IMEM_AW    = 6;
    localparam logic [31:0] NOP_INSTR  = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Host programming stream (valid/ready with start and last markers).
// The host drives the master side and the boot loader is the slave.
interface imem_boot_loader_if;

    logic        host_start;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;
    logic        host_ready;

    modport master (
        output host_start,
        output host_valid,
        output host_data,
        output host_last,
        input  host_ready
    );

    modport slave (
        input  host_start,
        input  host_valid,
        input  host_data,
        input  host_last,
        output host_ready
    );

endinterface

// File: rtl/imem_boot_loader.sv
// Arbitrates the single-port instruction memory between host programming and CPU fetch.
// Define IMEM_CHECKSUM_EN to add the load_csum XOR checksum output.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_boot_loader_if.slave    host,
    input  logic [31:0]          cpu_fetch_addr,
    output logic [31:0]          cpu_instr,
    output logic                 cpu_stall,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    output logic [AW:0]          load_count,
    output logic                 busy
`ifdef IMEM_CHECKSUM_EN
    ,
    output logic [31:0]          load_csum
`endif
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_t      r_state;
    logic [AW:0] r_ptr;
    logic [AW:0] r_loadCount;

    state_t      w_nextState;
    logic [AW:0] w_nextPtr;
    logic [AW:0] w_nextCount;
    logic        w_xfer;
    logic        w_loadEntry;
    logic        w_memWe;
    logic [31:0] w_wdata;
    logic        w_hostReady;
    logic        w_unusedAddrBits;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_loadCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_ptr       <= w_nextPtr;
            r_loadCount <= w_nextCount;
        end
    end

    // A start pulse in LOAD restarts the load and swallows any coincident transfer.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextCount = r_loadCount;
        w_xfer      = 1'b0;
        w_loadEntry = 1'b0;
        w_memWe     = 1'b0;
        w_wdata     = NOP_INSTR;
        w_hostReady = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (host.host_start) begin
                    w_nextState = LOAD;
                    w_nextPtr   = '0;
                    w_loadEntry = 1'b1;
                end
            end
            LOAD: begin
                w_hostReady = 1'b1;
                if (host.host_start) begin
                    w_nextPtr   = '0;
                    w_loadEntry = 1'b1;
                end else if (host.host_valid) begin
                    w_xfer      = 1'b1;
                    w_memWe     = 1'b1;
                    w_wdata     = host.host_data;
                    w_nextPtr   = r_ptr + 1'b1;
                    w_nextCount = r_ptr + 1'b1;
                    if (r_ptr == LAST_IDX) begin
                        w_nextState = RUN;
                    end else if (host.host_last) begin
                        w_nextState = CLEAR;
                    end
                end
            end
            CLEAR: begin
                w_memWe   = 1'b1;
                w_nextPtr = r_ptr + 1'b1;
                if (r_ptr == LAST_IDX) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (host.host_start) begin
                    w_nextState = LOAD;
                    w_nextPtr   = '0;
                    w_loadEntry = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Writes are suppressed during the reset cycle so reset never disturbs memory.
    assign mem_we           = w_memWe & ~reset;
    assign mem_wdata        = w_wdata;
    assign mem_addr         = (r_state == RUN) ? cpu_fetch_addr[AW+1:2] : r_ptr[AW-1:0];
    assign cpu_instr        = (r_state == RUN) ? mem_rdata : NOP_INSTR;
    assign cpu_stall        = (r_state != RUN);
    assign busy             = (r_state == LOAD) || (r_state == CLEAR);
    assign load_count       = r_loadCount;
    assign host.host_ready  = w_hostReady;
    assign w_unusedAddrBits = ^{cpu_fetch_addr[31:AW+2], cpu_fetch_addr[1:0]};

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_loadEntry) begin
            r_csum <= '0;
        end else if (w_xfer) begin
            r_csum <= r_csum ^ host.host_data;
        end
    end

    assign load_csum = r_csum;
`else
    logic w_unusedCsumCtl;
    assign w_unusedCsumCtl = w_loadEntry ^ w_xfer;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader with a behavioural async-read memory.
// Checksum checks are compiled in when IMEM_CHECKSUM_EN is defined.
module tb_imem_boot_loader;
    import imem_pkg::*;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic [31:0] cpu_fetch_addr;
    logic [31:0] cpu_instr;
    logic        cpu_stall;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [6:0]  load_count;
    logic        busy;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0] load_csum;
`endif

    imem_boot_loader_if hostIf ();

    logic [31:0] memArray [64];
    logic [31:0] image [64];
    wr_t         expQ [$];
    int          checks = 0;
    int          passes = 0;
    bit          monEn = 1'b0;

    imem_boot_loader dut (
        .clk            (clk),
        .reset          (reset),
        .host           (hostIf),
        .cpu_fetch_addr (cpu_fetch_addr),
        .cpu_instr      (cpu_instr),
        .cpu_stall      (cpu_stall),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .load_count     (load_count),
        .busy           (busy)
`ifdef IMEM_CHECKSUM_EN
        ,
        .load_csum      (load_csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = memArray[mem_addr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) memArray[mem_addr] <= mem_wdata;
    end

    // Every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (monEn && mem_we === 1'b1) begin
            wr_t e;
            checks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", mem_addr, mem_wdata);
            end else begin
                e = expQ.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data)
                    $display("[TB] FAIL write_stream: got addr %0d data %h, required addr %0d data %h",
                             mem_addr, mem_wdata, e.addr, e.data);
                else
                    passes++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input bit s, input bit v, input logic [31:0] d, input bit l);
        @(posedge clk);
        #1;
        hostIf.host_start = s;
        hostIf.host_valid = v;
        hostIf.host_data  = d;
        hostIf.host_last  = l;
    endtask

    task automatic pushLoad(input int idx, input logic [31:0] d);
        wr_t e;
        e.addr = 6'(idx);
        e.data = d;
        expQ.push_back(e);
        image[idx] = d;
    endtask

    task automatic pushClear(input int fromIdx);
        for (int i = fromIdx; i < 64; i++) pushLoad(i, 32'h0);
    endtask

    task automatic waitRun(input int budget, output bit ok);
        int n = 0;
        while (cpu_stall !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (cpu_stall === 1'b0);
    endtask

    task automatic setFetch(input logic [31:0] a);
        @(posedge clk);
        #1;
        cpu_fetch_addr = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        monEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_stall, cpu_instr, hostIf.host_ready, mem_we, busy} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b0})
                $display("[TB] FAIL reset_idle: got stall %b instr %h ready %b we %b busy %b, required 1 0 0 0 0",
                         cpu_stall, cpu_instr, hostIf.host_ready, mem_we, busy);
            else
                passes++;
        end
        checks++;
        if (load_count !== 7'd0) $display("[TB] FAIL reset_count: got %0d required 0", load_count);
        else passes++;
    endtask

    task automatic test_load3();
        bit ok;
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h20080020, 0);
        pushLoad(0, 32'h20080020);
        @(negedge clk);
        checks++;
        if ({hostIf.host_ready, busy, cpu_stall, cpu_instr} !== {1'b1, 1'b1, 1'b1, 32'h0})
            $display("[TB] FAIL load_state: got ready %b busy %b stall %b instr %h, required 1 1 1 0",
                     hostIf.host_ready, busy, cpu_stall, cpu_instr);
        else passes++;
        applyStimulus(0, 1, 32'h20090037, 0);
        pushLoad(1, 32'h20090037);
        applyStimulus(0, 1, 32'h01098024, 1);
        pushLoad(2, 32'h01098024);
        applyStimulus(0, 0, 32'h0, 0);
        pushClear(3);
        @(negedge clk);
        checks++;
        if ({hostIf.host_ready, busy, cpu_stall} !== {1'b0, 1'b1, 1'b1})
            $display("[TB] FAIL clear_state: got ready %b busy %b stall %b, required 0 1 1",
                     hostIf.host_ready, busy, cpu_stall);
        else passes++;
        waitRun(100, ok);
        checks++;
        if (!ok) $display("[TB] FAIL load3_run: got stall %b required 0", cpu_stall);
        else passes++;
        checks++;
        if (expQ.size() != 0 || load_count !== 7'd3 || busy !== 1'b0)
            $display("[TB] FAIL load3_done: got pending %0d count %0d busy %b, required 0 3 0",
                     expQ.size(), load_count, busy);
        else passes++;
        setFetch(32'h8);
        checks++;
        if (cpu_instr !== 32'h01098024) $display("[TB] FAIL fetch_08: got %h required %h", cpu_instr, 32'h01098024);
        else passes++;
        setFetch(32'h10C);
        checks++;
        if (cpu_instr !== 32'h0) $display("[TB] FAIL fetch_wrap_10c: got %h required %h", cpu_instr, 32'h0);
        else passes++;
        setFetch(32'h3);
        checks++;
        if (cpu_instr !== 32'h20080020) $display("[TB] FAIL fetch_offset_03: got %h required %h", cpu_instr, 32'h20080020);
        else passes++;
        setFetch(32'hFFFF_FF04);
        checks++;
        if (cpu_instr !== 32'h20090037) $display("[TB] FAIL fetch_upper_bits: got %h required %h", cpu_instr, 32'h20090037);
        else passes++;
    endtask

    task automatic test_backpressure();
        bit ok;
        applyStimulus(1, 0, 32'h0, 0);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || mem_we !== 1'b0)
            $display("[TB] FAIL start_same_cycle: got stall %b we %b, required 0 0", cpu_stall, mem_we);
        else passes++;
        applyStimulus(0, 1, 32'hA1A1_0001, 0);
        pushLoad(0, 32'hA1A1_0001);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b1) $display("[TB] FAIL start_stall_next: got %b required 1", cpu_stall);
        else passes++;
        applyStimulus(0, 0, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || hostIf.host_ready !== 1'b1)
            $display("[TB] FAIL gap_no_write: got we %b ready %b, required 0 1", mem_we, hostIf.host_ready);
        else passes++;
        applyStimulus(0, 1, 32'hB2B2_0002, 0);
        pushLoad(1, 32'hB2B2_0002);
        applyStimulus(0, 0, 32'hDEAD_BEEF, 1);
        applyStimulus(0, 1, 32'hC3C3_0003, 1);
        pushLoad(2, 32'hC3C3_0003);
        applyStimulus(0, 0, 32'h0, 0);
        pushClear(3);
        waitRun(100, ok);
        checks++;
        if (!ok || expQ.size() != 0 || load_count !== 7'd3)
            $display("[TB] FAIL backpressure_done: got run %b pending %0d count %0d, required 1 0 3",
                     ok, expQ.size(), load_count);
        else passes++;
        setFetch(32'h4);
        checks++;
        if (cpu_instr !== image[1]) $display("[TB] FAIL bp_fetch_04: got %h required %h", cpu_instr, image[1]);
        else passes++;
    endtask

    task automatic test_full_load();
        logic [31:0] d;
        int idxs[4] = '{0, 31, 63, 69};
        applyStimulus(1, 0, 32'h0, 0);
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            applyStimulus(0, 1, d, 0);
            pushLoad(i, d);
        end
        applyStimulus(0, 0, 32'h0, 0);
        @(negedge clk);
        checks++;
        if (cpu_stall !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL full_no_clear: got stall %b busy %b, required 0 0", cpu_stall, busy);
        else passes++;
        checks++;
        if (load_count !== 7'd64 || expQ.size() != 0)
            $display("[TB] FAIL full_count: got count %0d pending %0d, required 64 0", load_count, expQ.size());
        else passes++;
        foreach (idxs[k]) begin
            setFetch(32'(idxs[k] * 4));
            checks++;
            if (cpu_instr !== image[idxs[k] % 64])
                $display("[TB] FAIL full_fetch_%0d: got %h required %h", idxs[k], cpu_instr, image[idxs[k] % 64]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [31:0] d;
        applyStimulus(1, 0, 32'h0, 0);
        for (int i = 0; i < 20; i++) begin
            d = 32'h5500_0000 | 32'(i);
            applyStimulus(0, 1, d, (i == 19));
            pushLoad(i, d);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        hostIf.host_valid = 1'b0;
        hostIf.host_last  = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) $display("[TB] FAIL reset_cycle_write: got we %b required 0", mem_we);
        else passes++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, mem_we, cpu_stall, hostIf.host_ready, cpu_instr} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'h0})
                $display("[TB] FAIL mid_clear_idle: got busy %b we %b stall %b ready %b instr %h, required 0 0 1 0 0",
                         busy, mem_we, cpu_stall, hostIf.host_ready, cpu_instr);
            else passes++;
        end
        checks++;
        if (load_count !== 7'd0 || expQ.size() != 0)
            $display("[TB] FAIL mid_clear_count: got count %0d pending %0d, required 0 0", load_count, expQ.size());
        else passes++;
    endtask

    task automatic test_restart_in_load();
        bit ok;
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h1111_1111, 0);
        pushLoad(0, 32'h1111_1111);
        applyStimulus(1, 1, 32'hBAD0_BAD0, 0);
        applyStimulus(0, 1, 32'h7777_0000, 0);
        pushLoad(0, 32'h7777_0000);
        applyStimulus(0, 1, 32'h7777_0001, 1);
        pushLoad(1, 32'h7777_0001);
        applyStimulus(0, 0, 32'h0, 0);
        pushClear(2);
        waitRun(100, ok);
        checks++;
        if (!ok || expQ.size() != 0 || load_count !== 7'd2)
            $display("[TB] FAIL restart_done: got run %b pending %0d count %0d, required 1 0 2",
                     ok, expQ.size(), load_count);
        else passes++;
        setFetch(32'h0);
        checks++;
        if (cpu_instr !== 32'h7777_0000) $display("[TB] FAIL restart_fetch_0: got %h required %h", cpu_instr, 32'h7777_0000);
        else passes++;
        setFetch(32'h14);
        checks++;
        if (cpu_instr !== 32'h0) $display("[TB] FAIL restart_fetch_5: got %h required %h", cpu_instr, 32'h0);
        else passes++;
    endtask

`ifdef IMEM_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        applyStimulus(1, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h0000_FFFF, 0);
        pushLoad(0, 32'h0000_FFFF);
        @(negedge clk);
        checks++;
        if (load_csum !== 32'h0) $display("[TB] FAIL csum_cleared: got %h required %h", load_csum, 32'h0);
        else passes++;
        applyStimulus(0, 1, 32'h00FF_00FF, 1);
        pushLoad(1, 32'h00FF_00FF);
        applyStimulus(0, 0, 32'h0, 0);
        pushClear(2);
        waitRun(100, ok);
        checks++;
        if (!ok || load_csum !== 32'h00FF_FF00)
            $display("[TB] FAIL csum_value: got run %b csum %h, required 1 %h", ok, load_csum, 32'h00FF_FF00);
        else passes++;
    endtask
`endif

    initial begin
        reset             = 1'b1;
        cpu_fetch_addr    = 32'h0;
        hostIf.host_start = 1'b0;
        hostIf.host_valid = 1'b0;
        hostIf.host_data  = 32'h0;
        hostIf.host_last  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            memArray[i] = 32'h0;
            image[i]    = 32'h0;
        end
        test_reset();
        test_load3();
        test_backpressure();
        test_full_load();
        test_reset_mid_clear();
        test_restart_in_load();
`ifdef IMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Sequences the single-port instruction memory (64 x 32-bit words, asynchronous read) between two users: a host programming stream and CPU instruction fetch.
- After reset, holds the CPU stalled and accepts program words over a valid/ready stream.
- Zero-fills the unloaded tail of the memory.
- Then releases the CPU and routes its fetch address to the memory.
- Sits between the PC/fetch stage and the instruction memory array.

Parameters:
- DEPTH, 64: number of instruction words in the memory.
- AW, 6: word-index width; must equal clog2(DEPTH).

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- host_start, input, 1: one-cycle pulse that begins a (re)load.
- host_valid, input, 1: host word valid.
- host_data, input, 32: program word.
- host_last, input, 1: marks the final word of the program.
- host_ready, output, 1: loader accepts a word this cycle.
- cpu_fetch_addr, input, 32: byte address from the PC.
- cpu_instr, output, 32: instruction delivered to the CPU.
- cpu_stall, output, 1: CPU must hold its PC.
- mem_we, output, 1: memory write enable, sampled on the clk edge.
- mem_addr, output, AW: memory word index.
- mem_wdata, output, 32: memory write data.
- mem_rdata, input, 32: memory asynchronous read data.
- load_count, output, AW+1: number of host words written in the last load.
- busy, output, 1: high in LOAD or CLEAR.

Behaviour:
- FSM states: IDLE, LOAD, CLEAR, RUN, held in a state register updated on posedge clk.
- Reset (any state, including mid-load or mid-clear) gives:
  - state = IDLE, word pointer ptr = 0, load_count = 0;
  - outputs host_ready = 0, mem_we = 0, cpu_stall = 1, cpu_instr = 0, busy = 0.
  - Memory contents are not touched by reset.
- IDLE:
  - cpu_stall = 1, cpu_instr = 0 (NOP).
  - host_start moves to LOAD with ptr = 0.
- LOAD:
  - host_ready = 1.
  - A transfer happens when host_valid && host_ready. That same cycle: mem_we = 1, mem_addr = ptr, mem_wdata = host_data. Then ptr increments and load_count = ptr + 1.
  - No transfer in a cycle means mem_we = 0 and state holds.
  - Transfer with host_last, or with ptr == DEPTH-1, moves to CLEAR with ptr + 1.
  - If ptr + 1 == DEPTH, CLEAR is skipped and the next state is RUN.
  - host_start while in LOAD restarts: ptr = 0, and any accompanying transfer is ignored.
- CLEAR:
  - host_ready = 0.
  - Each cycle: mem_we = 1, mem_addr = ptr, mem_wdata = 0, ptr increments.
  - After the cycle writing DEPTH-1, go to RUN.
  - host_start is ignored.
- RUN:
  - cpu_stall = 0, mem_we = 0.
  - mem_addr = cpu_fetch_addr[AW+1:2]; cpu_instr = mem_rdata, combinational, zero latency.
  - Byte offset bits [1:0] are ignored. Upper address bits above AW+1 are ignored, so fetch wraps modulo DEPTH.
  - host_start goes to LOAD and asserts cpu_stall from the next cycle.
- In every state other than RUN:
  - mem_addr is driven from ptr;
  - cpu_instr = 0 and cpu_stall = 1.
- busy = (state == LOAD) || (state == CLEAR).
- host_ready is a registered-state decode only; it never depends combinationally on host_valid.

Optional Feature:
IMEM_CHECKSUM_EN.
- Defined: adds output load_csum[31:0], reset 0.
  - Cleared to 0 on the cycle LOAD is entered.
  - XOR-accumulates host_data on every accepted transfer.
  - Holds its value in CLEAR and RUN.
- Undefined: the port and the logic are absent; all other behaviour is identical.

Decomposition:
- Shared package imem_pkg holds:
  - the state encoding localparams (IDLE = 2'd0, LOAD = 2'd1, CLEAR = 2'd2, RUN = 2'd3);
  - IMEM_DEPTH = 64 and IMEM_AW = 6;
  - NOP_INSTR = 32'h0.
- No sub-module. The address/data mux and the FSM stay in one module; the memory array stays external.

Test Plan:
- Reset then idle: cpu_stall = 1, cpu_instr = 0, host_ready = 0, mem_we = 0 for 5 cycles.
- Load 3 words (20080020, 20090037, 01098024) with host_last on the third:
  - 3 writes at indices 0, 1, 2;
  - then 61 zero writes at indices 3..63;
  - then RUN;
  - fetch 0x8 returns 01098024, and fetch 0x10C returns word 3 (wrap) = 0.
- Backpressure gaps: host_valid toggles every other cycle; exactly one write per accepted word, and load_count = 3 at the end.
- Full load of 64 words without host_last: goes LOAD to RUN directly, with no CLEAR cycles.
- Reset asserted mid-CLEAR at ptr = 20: next cycle IDLE, mem_we = 0, cpu_stall = 1.
- host_start during RUN: cpu_stall rises the next cycle and ptr restarts at 0. With IMEM_CHECKSUM_EN defined, loading 0x0000FFFF then 0x00FF00FF gives load_csum = 0x00FFFF00.
